// File: rtl/scroll_sequencer_if.sv
// Scene-side bundle for scroll_sequencer: frame sync and user switches in,
// scroll offset, visibility and frame strobe out.
// master = the sequencer, slave = the scene/player/LUT datapath driving it.
interface scroll_sequencer_if;
   logic       vsync;
   logic [3:0] speed_sw;
   logic       dir_sw;
   logic       pause_sw;
   logic [9:0] x_offset;
   logic       started;
   logic       frame_tick;
   logic [3:0] cur_speed;
   logic       cur_dir;

   modport master (
      input  vsync, speed_sw, dir_sw, pause_sw,
      output x_offset, started, frame_tick, cur_speed, cur_dir
   );

   modport slave (
      output vsync, speed_sw, dir_sw, pause_sw,
      input  x_offset, started, frame_tick, cur_speed, cur_dir
   );
endinterface

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: frame-synchronous scroll controller for the sine scene.
// All state advances only on a frame edge (rising vsync). Switches are
// synchronised, sampled at the frame edge, and turned into an offset that
// wraps modulo PERIOD.
// Build option: define SCROLL_RAMP_EN for ramped speed (+/-1 per frame) with
// braking to zero before a direction reversal; without it, speed and
// direction jump to the target on each running frame edge.
// PERIOD must lie in 16..1023 so that offset + speed fits in 11 bits.
module scroll_sequencer #(
   parameter int PERIOD       = 400,
   parameter int START_FRAMES = 0
) (
   input logic               clk,
   input logic               rst_n,
   scroll_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_RUN   = 2'd1,
      ST_BRAKE = 2'd2
   } state_t;

   localparam int          CNT_W    = (START_FRAMES > 1) ? $clog2(START_FRAMES + 1) : 1;
   localparam logic [10:0] PERIOD_W = 11'(PERIOD);

   // Switch synchronisers: {pause, dir, speed[3:0]}
   logic [5:0] sw_meta;
   logic [5:0] sw_sync;
   logic       vsync_d;
   logic       fe;

   state_t     state;
   logic [CNT_W-1:0] cnt;
   logic [9:0] x_offset_q;
   logic       started_q;
   logic       frame_tick_q;
   logic [3:0] cur_speed_q;
   logic       cur_dir_q;

   logic [3:0]  target_speed;
   logic        target_dir;
   logic [10:0] sum_fwd;
   logic [10:0] off_fwd;
   logic [10:0] off_rev;
   logic [9:0]  next_off;

   // Two-flop synchronisers for the raw switches and the vsync delay tap.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
         vsync_d <= 1'b0;
      end else begin
         sw_meta <= {bus.pause_sw, bus.dir_sw, bus.speed_sw};
         sw_sync <= sw_meta;
         vsync_d <= bus.vsync;
      end
   end

   assign fe = bus.vsync & ~vsync_d;

   // Target selection and wrap arithmetic from the pre-edge speed/direction.
   // NOTE: every always_comb output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      target_speed = sw_sync[3:0];
      target_dir   = sw_sync[4];
      if (sw_sync[5])
         target_speed = 4'd0;
      else if (sw_sync[3:0] == 4'd0)
         target_speed = 4'd1;

      sum_fwd = {1'b0, x_offset_q} + 11'(cur_speed_q);
      off_fwd = (sum_fwd >= PERIOD_W) ? (sum_fwd - PERIOD_W) : sum_fwd;
      if ({1'b0, x_offset_q} >= 11'(cur_speed_q))
         off_rev = {1'b0, x_offset_q} - 11'(cur_speed_q);
      else
         off_rev = {1'b0, x_offset_q} + PERIOD_W - 11'(cur_speed_q);

      next_off = cur_dir_q ? off_rev[9:0] : off_fwd[9:0];
   end

   // Sequencer FSM with registered outputs; advances only on frame edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_START;
         cnt          <= '0;
         x_offset_q   <= '0;
         started_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         cur_speed_q  <= '0;
         cur_dir_q    <= 1'b0;
      end else begin
         frame_tick_q <= fe;
         if (fe) begin
            case (state)
               ST_START: begin
                  if (cnt == CNT_W'(START_FRAMES)) begin
                     state     <= ST_RUN;
                     started_q <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_RUN: begin
                  x_offset_q <= next_off;
`ifdef SCROLL_RAMP_EN
                  if (target_dir != cur_dir_q) begin
                     if (cur_speed_q != 4'd0)
                        state <= ST_BRAKE;
                     else
                        cur_dir_q <= target_dir;
                  end else if (cur_speed_q < target_speed) begin
                     cur_speed_q <= cur_speed_q + 4'd1;
                  end else if (cur_speed_q > target_speed) begin
                     cur_speed_q <= cur_speed_q - 4'd1;
                  end
`else
                  cur_speed_q <= target_speed;
                  cur_dir_q   <= target_dir;
`endif
               end
               ST_BRAKE: begin
                  x_offset_q <= next_off;
                  if (cur_speed_q == 4'd0) begin
                     cur_dir_q <= target_dir;
                     state     <= ST_RUN;
                  end else begin
                     cur_speed_q <= cur_speed_q - 4'd1;
                  end
               end
               default: state <= ST_START;
            endcase
         end
      end
   end

   assign bus.x_offset   = x_offset_q;
   assign bus.started    = started_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.cur_speed  = cur_speed_q;
   assign bus.cur_dir    = cur_dir_q;

endmodule
